// File: rtl/axi4_accel_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi4_accel_bridge
// Brief    : AXI4-lite register bridge between picoRV32 and the MNIST
//            accelerator. Optional done interrupt: define ACCEL_IRQ_EN.
// Revision : 1.0
// ============================================================================
module axi4_accel_bridge #(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          IMG_WORDS     = 785,
    parameter int          RES_WORDS     = 10,
    parameter int          SCRATCH_WORDS = 4096,
    parameter int          RESET_CYCLES  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [31:0]             s_awaddr,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic [31:0]             s_wdata,
    input  logic [3:0]              s_wstrb,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [1:0]              s_bresp,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    input  logic [31:0]             s_araddr,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [31:0]             s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    acc_reset,
    output logic [IMG_WORDS*32-1:0] acc_image,
    input  logic                    acc_ready,
    input  logic [RES_WORDS*32-1:0] acc_result
`ifdef ACCEL_IRQ_EN
    ,
    output logic                    irq
`endif
);

    localparam int c_IMG_IDX_W = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
    localparam int c_RES_IDX_W = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;
    localparam int c_SCR_IDX_W = (SCRATCH_WORDS > 1) ? $clog2(SCRATCH_WORDS) : 1;
    localparam int c_CNT_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [31:0] c_IMG_WORDS = 32'(IMG_WORDS);
    localparam logic [31:0] c_RES_WORDS = 32'(RES_WORDS);
    localparam logic [31:0] c_SCR_WORDS = 32'(SCRATCH_WORDS);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        REG_NONE, REG_CTRL, REG_STATUS, REG_RESULT, REG_IMAGE, REG_SCRATCH
    } region_t;
    typedef enum logic [0:0] {R_IDLE, R_RESP} rd_state_t;
    typedef enum logic [0:0] {W_IDLE, W_RESP} wr_state_t;

    function automatic region_t decode(input logic [31:0] addr);
        logic [31:0] off;
        region_t     reg_sel;
        off     = addr - BASE_ADDR;
        reg_sel = REG_NONE;
        if (off[31:2] == 30'd0)
            reg_sel = REG_CTRL;
        else if (off[31:2] == 30'd1)
            reg_sel = REG_STATUS;
        else if (off[31:8] == 24'h1 && {26'd0, off[7:2]} < c_RES_WORDS)
            reg_sel = REG_RESULT;
        else if (off[31:12] == 20'h1 && {22'd0, off[11:2]} < c_IMG_WORDS)
            reg_sel = REG_IMAGE;
        else if (off[31:16] == 16'h1 && {18'd0, off[15:2]} < c_SCR_WORDS)
            reg_sel = REG_SCRATCH;
        return reg_sel;
    endfunction

    function automatic logic [c_IMG_IDX_W-1:0] img_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off[2 +: c_IMG_IDX_W];
    endfunction

    function automatic logic [c_RES_IDX_W-1:0] res_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off[2 +: c_RES_IDX_W];
    endfunction

    function automatic logic [c_SCR_IDX_W-1:0] scr_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off[2 +: c_SCR_IDX_W];
    endfunction

    logic [31:0] r_image   [IMG_WORDS];
    logic [31:0] r_result  [RES_WORDS];
    logic [31:0] r_scratch [SCRATCH_WORDS];
    logic        r_busy, r_done, r_acc_reset;
    logic [c_CNT_W-1:0] r_cnt;
    logic        w_irq_en;

    // ---------------- read channel ----------------
    rd_state_t   r_rd_state, w_rd_next;
    region_t     w_rd_region;
    logic [31:0] w_rd_data;
    logic        w_rd_err, w_ar_hs;

    assign s_arready = (r_rd_state == R_IDLE) && !reset;
    assign s_rvalid  = (r_rd_state == R_RESP);
    assign w_ar_hs   = s_arvalid && s_arready;

    always_comb begin
        w_rd_region = decode(s_araddr);
        w_rd_data   = '0;
        w_rd_err    = 1'b0;
        case (w_rd_region)
            REG_CTRL:    w_rd_data = {30'd0, w_irq_en, 1'b0};
            REG_STATUS:  w_rd_data = {30'd0, r_done, r_busy};
            REG_RESULT:  w_rd_data = r_result[res_idx(s_araddr)];
            REG_IMAGE:   w_rd_data = r_image[img_idx(s_araddr)];
            REG_SCRATCH: w_rd_data = r_scratch[scr_idx(s_araddr)];
            default:     w_rd_err  = 1'b1;
        endcase
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs) w_rd_next = R_RESP;
            R_RESP:  if (s_rready) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= R_IDLE;
            s_rdata    <= '0;
            s_rresp    <= 2'b00;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_ar_hs) begin
                s_rdata <= w_rd_data;
                s_rresp <= w_rd_err ? 2'b10 : 2'b00;
            end
        end
    end

    // ---------------- write channel ----------------
    wr_state_t   r_wr_state, w_wr_next;
    logic        r_aw_full, r_w_full;
    logic [31:0] r_awaddr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        w_aw_hs, w_w_hs, w_commit, w_wr_err;
    logic [31:0] w_wr_addr, w_wr_data;
    logic [3:0]  w_wr_strb;
    region_t     w_wr_region;

    assign s_awready   = !r_aw_full && !reset;
    assign s_wready    = !r_w_full && !reset;
    assign s_bvalid    = (r_wr_state == W_RESP);
    assign w_aw_hs     = s_awvalid && s_awready;
    assign w_w_hs      = s_wvalid && s_wready;
    assign w_wr_addr   = r_aw_full ? r_awaddr : s_awaddr;
    assign w_wr_data   = r_w_full ? r_wdata : s_wdata;
    assign w_wr_strb   = r_w_full ? r_wstrb : s_wstrb;
    assign w_wr_region = decode(w_wr_addr);
    assign w_wr_err    = (w_wr_region == REG_NONE) || (w_wr_region == REG_RESULT);
    // Commit on the edge where the later of the two beats is accepted.
    assign w_commit    = (r_wr_state == W_IDLE) && (r_aw_full || w_aw_hs)
                         && (r_w_full || w_w_hs);

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_commit) w_wr_next = W_RESP;
            W_RESP:  if (s_bready) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= W_IDLE;
            r_aw_full  <= 1'b0;
            r_w_full   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            s_bresp    <= 2'b00;
        end else begin
            r_wr_state <= w_wr_next;
            if (r_wr_state == W_RESP && s_bready) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_full <= 1'b1;
                    r_awaddr  <= s_awaddr;
                end
                if (w_w_hs) begin
                    r_w_full <= 1'b1;
                    r_wdata  <= s_wdata;
                    r_wstrb  <= s_wstrb;
                end
            end
            if (w_commit)
                s_bresp <= w_wr_err ? 2'b10 : 2'b00;
        end
    end

    // ---------------- control / status ----------------
    logic w_ctrl_wr, w_start, w_w1c, w_complete;

    assign w_ctrl_wr  = w_commit && (w_wr_region == REG_CTRL) && w_wr_strb[0];
    assign w_start    = w_ctrl_wr && w_wr_data[0];
    assign w_w1c      = w_commit && (w_wr_region == REG_STATUS) && w_wr_strb[0] && w_wr_data[1];
    assign w_complete = r_busy && !r_acc_reset && acc_ready;
    assign acc_reset  = r_acc_reset;

    // Later assignments win: completion beats W1C, a new start beats both.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_acc_reset <= 1'b1;
            r_cnt       <= '0;
        end else begin
            if (w_w1c)
                r_done <= 1'b0;
            if (w_complete) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
            if (r_busy && r_acc_reset) begin
                if (r_cnt == '0)
                    r_acc_reset <= 1'b0;
                else
                    r_cnt <= r_cnt - 1'b1;
            end
            if (w_start) begin
                r_done      <= 1'b0;
                r_busy      <= 1'b1;
                r_acc_reset <= 1'b1;
                r_cnt       <= c_CNT_INIT;
            end
        end
    end

`ifdef ACCEL_IRQ_EN
    logic r_irq_en, r_irq;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr)
                r_irq_en <= w_wr_data[1];
            r_irq <= r_done && r_irq_en;
        end
    end
    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
`endif

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < RES_WORDS; k++)
                r_result[k] <= '0;
        end else if (w_complete) begin
            for (int k = 0; k < RES_WORDS; k++)
                r_result[k] <= acc_result[32*k +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < IMG_WORDS; j++)
                r_image[j] <= '0;
        end else if (w_commit && w_wr_region == REG_IMAGE) begin
            for (int b = 0; b < 4; b++)
                if (w_wr_strb[b])
                    r_image[img_idx(w_wr_addr)][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
    end

    // Scratch RAM carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_commit && w_wr_region == REG_SCRATCH) begin
            for (int b = 0; b < 4; b++)
                if (w_wr_strb[b])
                    r_scratch[scr_idx(w_wr_addr)][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
    end

    for (genvar j = 0; j < IMG_WORDS; j++) begin : g_img
        assign acc_image[32*j +: 32] = r_image[j];
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_accel_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_accel_bridge
// Brief    : Directed self-checking bench for axi4_accel_bridge.
// Revision : 1.0
// ============================================================================
module tb_axi4_accel_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_awvalid = 0, s_awready;
    logic [31:0]   s_awaddr = 0;
    logic          s_wvalid = 0, s_wready;
    logic [31:0]   s_wdata = 0;
    logic [3:0]    s_wstrb = 0;
    logic          s_bvalid, s_bready = 0;
    logic [1:0]    s_bresp;
    logic          s_arvalid = 0, s_arready;
    logic [31:0]   s_araddr = 0;
    logic          s_rvalid, s_rready = 0;
    logic [31:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic          acc_reset;
    logic [785*32-1:0] acc_image;
    logic          acc_ready = 0;
    logic [10*32-1:0] acc_result = '0;
`ifdef ACCEL_IRQ_EN
    logic          irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi4_accel_bridge dut (
        .clk(clk), .reset(reset),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .acc_reset(acc_reset), .acc_image(acc_image),
        .acc_ready(acc_ready), .acc_result(acc_result)
`ifdef ACCEL_IRQ_EN
        , .irq(irq)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] st, output logic [1:0] resp);
        int n;
        bit aw_done, w_done, aw_hs, w_hs;
        n = 0; aw_done = 0; w_done = 0;
        @(negedge clk);
        s_awvalid = 1; s_awaddr = a; s_wvalid = 1; s_wdata = d; s_wstrb = st; s_bready = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(negedge clk);
            n++;
            if (aw_hs) begin aw_done = 1; s_awvalid = 0; end
            if (w_hs)  begin w_done = 1;  s_wvalid = 0;  end
        end
        n = 0;
        while (!s_bvalid && n < 50) begin @(negedge clk); n++; end
        if (!s_bvalid) begin
            timeout("axi_write");
            s_awvalid = 0; s_wvalid = 0; resp = 2'b11;
            return;
        end
        resp = s_bresp;
        s_bready = 1;
        @(negedge clk);
        s_bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        n = 0;
        @(negedge clk);
        s_arvalid = 1; s_araddr = a; s_rready = 0;
        while (!s_arready && n < 50) begin @(negedge clk); n++; end
        if (!s_arready) begin
            timeout("axi_read");
            s_arvalid = 0; d = '0; resp = 2'b11;
            return;
        end
        @(negedge clk);
        s_arvalid = 0;
        check("rvalid_latency", 32'(s_rvalid), 32'd1);
        d = s_rdata;
        resp = s_rresp;
        s_rready = 1;
        @(negedge clk);
        s_rready = 0;
    endtask

    task automatic wait_acc_reset_low();
        int n;
        n = 0;
        while (acc_reset && n < 50) begin @(negedge clk); n++; end
        if (acc_reset) timeout("acc_reset_low");
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] off;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        logic [1:0]  resp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] exp_ctrl;
        int          n;

`ifdef ACCEL_IRQ_EN
        exp_ctrl = 32'h2;
`else
        exp_ctrl = 32'h0;
`endif
        vecs.push_back(vec_t'{1, 32'h10014, 32'h0000_0000, 4'hF, 32'h0, 2'b00, "scr5_clear"});
        vecs.push_back(vec_t'{1, 32'h10014, 32'hDEAD_BEEF, 4'h3, 32'h0, 2'b00, "scr5_strb_wr"});
        vecs.push_back(vec_t'{0, 32'h10014, 32'h0, 4'h0, 32'h0000_BEEF, 2'b00, "scr5_rd"});
        vecs.push_back(vec_t'{0, 32'h10015, 32'h0, 4'h0, 32'h0000_BEEF, 2'b00, "scr5_unaligned_rd"});
        vecs.push_back(vec_t'{1, 32'h01000, 32'h1122_3344, 4'hF, 32'h0, 2'b00, "img0_wr"});
        vecs.push_back(vec_t'{1, 32'h01000, 32'hAABB_CCDD, 4'h8, 32'h0, 2'b00, "img0_strb_wr"});
        vecs.push_back(vec_t'{0, 32'h01000, 32'h0, 4'h0, 32'hAA22_3344, 2'b00, "img0_rd"});
        vecs.push_back(vec_t'{0, 32'h00004, 32'h0, 4'h0, 32'h0, 2'b00, "status_reset_rd"});
        vecs.push_back(vec_t'{0, 32'h00000, 32'h0, 4'h0, 32'h0, 2'b00, "ctrl_reset_rd"});
        vecs.push_back(vec_t'{0, 32'h00800, 32'h0, 4'h0, 32'h0, 2'b10, "unmapped_rd"});
        vecs.push_back(vec_t'{1, 32'h00100, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10, "result0_wr"});
        vecs.push_back(vec_t'{0, 32'h00100, 32'h0, 4'h0, 32'h0, 2'b00, "result0_rd"});
        vecs.push_back(vec_t'{0, 32'h00128, 32'h0, 4'h0, 32'h0, 2'b10, "result10_rd"});
        vecs.push_back(vec_t'{0, 32'h01C44, 32'h0, 4'h0, 32'h0, 2'b10, "img785_rd"});
        vecs.push_back(vec_t'{1, 32'h01C44, 32'h1, 4'hF, 32'h0, 2'b10, "img785_wr"});
        vecs.push_back(vec_t'{1, 32'h13FFC, 32'h5A5A_5A5A, 4'hF, 32'h0, 2'b00, "scr4095_wr"});
        vecs.push_back(vec_t'{0, 32'h13FFC, 32'h0, 4'h0, 32'h5A5A_5A5A, 2'b00, "scr4095_rd"});
        vecs.push_back(vec_t'{0, 32'h14000, 32'h0, 4'h0, 32'h0, 2'b10, "scr4096_rd"});
        vecs.push_back(vec_t'{0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 2'b10, "below_base_rd"});
        vecs.push_back(vec_t'{1, 32'h00000, 32'h1, 4'hE, 32'h0, 2'b00, "ctrl_no_strb0_wr"});
        vecs.push_back(vec_t'{0, 32'h00004, 32'h0, 4'h0, 32'h0, 2'b00, "status_after_nostart"});
        vecs.push_back(vec_t'{1, 32'h00000, 32'h2, 4'hF, 32'h0, 2'b00, "ctrl_irqen_wr"});
        vecs.push_back(vec_t'{0, 32'h00000, 32'h0, 4'h0, exp_ctrl, 2'b00, "ctrl_irqen_rd"});

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(s_awready), 32'd0);
        check("rst_wready", 32'(s_wready), 32'd0);
        check("rst_arready", 32'(s_arready), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_acc_reset", 32'(acc_reset), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_acc_reset", 32'(acc_reset), 32'd1);
        check("post_rst_image0", acc_image[31:0], 32'd0);
        check("post_rst_bresp", 32'(s_bresp), 32'd0);
`ifdef ACCEL_IRQ_EN
        check("post_rst_irq", 32'(irq), 32'd0);
`endif

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(BASE + vecs[i].off, vecs[i].data, vecs[i].strb, r);
                check({vecs[i].name, "_bresp"}, 32'(r), 32'(vecs[i].resp));
            end else begin
                axi_read(BASE + vecs[i].off, d, r);
                check({vecs[i].name, "_data"}, d, vecs[i].exp);
                check({vecs[i].name, "_rresp"}, 32'(r), 32'(vecs[i].resp));
            end
        end

        // W beat three cycles ahead of AW, to IMAGE[784]
        @(negedge clk);
        s_wvalid = 1; s_wdata = 32'h12; s_wstrb = 4'hF; s_bready = 1;
        check("early_w_wready", 32'(s_wready), 32'd1);
        @(negedge clk);
        s_wvalid = 0;
        check("early_w_latched", 32'(s_wready), 32'd0);
        check("early_w_no_bvalid", 32'(s_bvalid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        s_awvalid = 1; s_awaddr = BASE + 32'h1C40;
        check("late_aw_awready", 32'(s_awready), 32'd1);
        @(negedge clk);
        s_awvalid = 0;
        check("late_aw_bvalid", 32'(s_bvalid), 32'd1);
        check("late_aw_bresp", 32'(s_bresp), 32'd0);
        check("acc_image_784", acc_image[25119:25088], 32'h12);
        @(negedge clk);
        s_bready = 0;
        check("late_aw_bvalid_clr", 32'(s_bvalid), 32'd0);

        // Start pulse length and completion
        @(negedge clk);
        s_awvalid = 1; s_awaddr = BASE; s_wvalid = 1; s_wdata = 32'h1; s_wstrb = 4'hF; s_bready = 1;
        check("start_ready", 32'(s_awready && s_wready), 32'd1);
        @(negedge clk);
        s_awvalid = 0; s_wvalid = 0;
        n = 0;
        while (acc_reset && n < 20) begin n++; @(negedge clk); end
        check("acc_reset_len", 32'(n), 32'd4);
        s_bready = 0;
        axi_read(BASE + 32'h4, d, r);
        check("status_busy", d, 32'h1);
        acc_result[32*3 +: 32] = 32'd7;
        acc_result[31:0]       = 32'h55;
        acc_ready = 1;
        @(negedge clk);
        acc_ready = 0;
        axi_read(BASE + 32'h4, d, r);
        check("status_done", d, 32'h2);
        axi_read(BASE + 32'h10C, d, r);
        check("result3", d, 32'd7);
        axi_read(BASE + 32'h100, d, r);
        check("result0", d, 32'h55);

        // W1C on the same edge as completion: set wins
        axi_write(BASE, 32'h1, 4'hF, r);
        wait_acc_reset_low();
        axi_read(BASE + 32'h4, d, r);
        check("restart_status", d, 32'h1);
        acc_result[31:0] = 32'h66;
        @(negedge clk);
        s_awvalid = 1; s_awaddr = BASE + 32'h4; s_wvalid = 1; s_wdata = 32'h2; s_wstrb = 4'hF;
        s_bready = 1; acc_ready = 1;
        @(negedge clk);
        s_awvalid = 0; s_wvalid = 0; acc_ready = 0;
        @(negedge clk);
        s_bready = 0;
        axi_read(BASE + 32'h4, d, r);
        check("w1c_race_status", d, 32'h2);
        axi_write(BASE + 32'h4, 32'h2, 4'hE, r);
        axi_read(BASE + 32'h4, d, r);
        check("w1c_nostrb_status", d, 32'h2);
        axi_write(BASE + 32'h4, 32'h2, 4'hF, r);
        axi_read(BASE + 32'h4, d, r);
        check("w1c_status", d, 32'h0);

        // Write to RESULT with bready held low
        @(negedge clk);
        s_awvalid = 1; s_awaddr = BASE + 32'h100; s_wvalid = 1; s_wdata = 32'hFFFF_FFFF;
        s_wstrb = 4'hF; s_bready = 0;
        @(negedge clk);
        s_awvalid = 0; s_wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            check("bvalid_hold", 32'(s_bvalid), 32'd1);
            check("bresp_hold", 32'(s_bresp), 32'd2);
            @(negedge clk);
        end
        s_bready = 1;
        @(negedge clk);
        s_bready = 0;
        check("bvalid_released", 32'(s_bvalid), 32'd0);
        axi_read(BASE + 32'h100, d, r);
        check("result0_unchanged", d, 32'h66);

`ifdef ACCEL_IRQ_EN
        axi_write(BASE, 32'h3, 4'hF, r);
        wait_acc_reset_low();
        acc_ready = 1;
        @(negedge clk);
        acc_ready = 0;
        check("irq_lags_done", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_set", 32'(irq), 32'd1);
        axi_write(BASE + 32'h4, 32'h2, 4'hF, r);
        check("irq_cleared", 32'(irq), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
